// File: rtl/wb_stream_writer.sv
// wb_stream_writer
//
// Buffered Wishbone write master. Words arrive on a valid/ready stream, each
// with an optional explicit address. They are queued in a small FIFO and
// issued as single-beat Wishbone writes. Back-to-back strobes are issued
// while the FIFO holds more work.
//
// Address resolution happens at push time. A word either carries its own
// address (in_addr_load = 1) or takes the running pointer. The pointer then
// advances by ADDR_STEP past whichever address was used, so the order of
// the input stream alone defines the write sequence.
//
// The word being written stays in the FIFO, and is still counted by
// fifo_level, until its cycle terminates. A termination is one of:
//   - ack;
//   - err, which is counted;
//   - an ack timeout, which is counted and followed by one recovery cycle.
//
// Ports
//   clk_100MHz     system clock, rising edge
//   reset          asynchronous active-high reset
//   in_valid       input word valid
//   in_ready       FIFO has room for a word
//   in_addr_load   1: use in_addr for this word, 0: use the running pointer
//   in_addr        explicit word address
//   in_data        write data
//   in_sel         byte enables
//   wb_cyc_o       Wishbone cycle
//   wb_stb_o       Wishbone strobe
//   wb_we_o        write enable, always 1
//   wb_adr_o       Wishbone address
//   wb_dat_o       Wishbone write data
//   wb_sel_o       Wishbone byte selects
//   wb_ack_i       slave acknowledge
//   wb_err_i       slave error
//   busy           FIFO non-empty or cycle in progress
//   fifo_level     entries held, including the one in flight
//   err_count      saturating count of err terminations
//   timeout_count  saturating count of aborted cycles

module wb_stream_writer #(
    parameter int unsigned ADDR_W     = 27,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_STEP  = 1,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                          clk_100MHz,
    input  logic                          reset,

    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_addr_load,
    input  logic [ADDR_W-1:0]             in_addr,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [DATA_W/8-1:0]           in_sel,

    output logic                          wb_cyc_o,
    output logic                          wb_stb_o,
    output logic                          wb_we_o,
    output logic [ADDR_W-1:0]             wb_adr_o,
    output logic [DATA_W-1:0]             wb_dat_o,
    output logic [DATA_W/8-1:0]           wb_sel_o,
    input  logic                          wb_ack_i,
    input  logic                          wb_err_i,

    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    err_count,
    output logic [7:0]                    timeout_count
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned ENT_W = ADDR_W + DATA_W + SEL_W;

    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(FIFO_DEPTH);
    // Abort on the edge where the counter would reach TIMEOUT.
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StRecover
    } state_e;

    state_e state_q, state_d;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_next;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [ADDR_W-1:0] addr_ptr_q, push_addr;
    logic              push, pop;

    // Registered Wishbone payload {adr, dat, sel}
    logic [ENT_W-1:0]  out_q;

    // Control decided by the next-state logic
    logic              load_head, load_next;
    logic              err_inc, to_inc;
    logic              timer_clr, timer_inc, timer_hit;
    logic [TO_W-1:0]   timer_q;
    logic [7:0]        err_cnt_q, to_cnt_q;

    // No push-through when full: a same-cycle pop does not open a slot.
    assign in_ready  = (level_q != FULL_LVL);
    assign push      = in_valid & in_ready;
    assign push_addr = in_addr_load ? in_addr : addr_ptr_q;
    assign rd_next   = rd_ptr_q + PTR_W'(1);
    assign timer_hit = (timer_q == TO_LAST);

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push && pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Storage has no reset; the level and pointers define validity.
    always_ff @(posedge clk_100MHz) begin
        if (push) begin
            mem[wr_ptr_q] <= {push_addr, in_data, in_sel};
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            addr_ptr_q <= '0;
        end else begin
            level_q <= level_d;
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
                // Wraps silently modulo 2^ADDR_W.
                addr_ptr_q <= push_addr + STEP;
            end
            if (pop) begin
                rd_ptr_q <= rd_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        load_head = 1'b0;
        load_next = 1'b0;
        pop       = 1'b0;
        err_inc   = 1'b0;
        to_inc    = 1'b0;
        timer_clr = 1'b0;
        timer_inc = 1'b0;

        case (state_q)
            StIdle: begin
                if (level_q != '0) begin
                    load_head = 1'b1;
                    timer_clr = 1'b1;
                    state_d   = StActive;
                end
            end

            StActive: begin
                if (wb_ack_i || wb_err_i) begin
                    pop       = 1'b1;
                    timer_clr = 1'b1;
                    // ack together with err counts as err.
                    err_inc   = wb_err_i;
                    // An entry behind the head is the next word: keep
                    // strobing without an idle cycle.
                    if (level_q > LVL_W'(1)) begin
                        load_next = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (timer_hit) begin
                    // Abandon the stuck word so the stream keeps moving.
                    pop       = 1'b1;
                    timer_clr = 1'b1;
                    to_inc    = 1'b1;
                    state_d   = StRecover;
                end else begin
                    timer_inc = 1'b1;
                end
            end

            StRecover: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // Decoded from state so an asynchronous reset drops cyc/stb at once.
    always_comb begin
        wb_cyc_o = 1'b0;
        wb_stb_o = 1'b0;
        if (state_q == StActive) begin
            wb_cyc_o = 1'b1;
            wb_stb_o = 1'b1;
        end
    end

    assign wb_we_o = 1'b1;
    assign {wb_adr_o, wb_dat_o, wb_sel_o} = out_q;

    // ------------------------------------------------------------------
    // Wishbone payload, timeout timer and status counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            out_q <= '0;
        end else if (load_head) begin
            out_q <= mem[rd_ptr_q];
        end else if (load_next) begin
            // The head is popped on this edge, so its successor is next.
            out_q <= mem[rd_next];
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else if (timer_clr) begin
            timer_q <= '0;
        end else if (timer_inc) begin
            timer_q <= timer_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            if (err_inc && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            if (to_inc && (to_cnt_q != 8'hFF)) begin
                to_cnt_q <= to_cnt_q + 8'd1;
            end
        end
    end

    assign err_count     = err_cnt_q;
    assign timeout_count = to_cnt_q;
    assign fifo_level    = level_q;
    assign busy          = (level_q != '0) | wb_cyc_o;

endmodule

// File: tb/tb_wb_stream_writer.sv
module tb_wb_stream_writer;

    localparam int AW    = 27;
    localparam int DW    = 32;
    localparam int SW    = 4;
    localparam int DEPTH = 16;
    localparam int TO    = 255;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, in_addr_load;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic [SW-1:0] in_sel;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [SW-1:0] wb_sel_o;
    logic          wb_ack_i, wb_err_i;
    logic          busy;
    logic [4:0]    fifo_level;
    logic [7:0]    err_count, timeout_count;

    wb_stream_writer #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .FIFO_DEPTH(DEPTH),
        .ADDR_STEP (1),
        .TIMEOUT   (TO)
    ) dut (
        .clk_100MHz   (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr_load (in_addr_load),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .in_sel       (in_sel),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_we_o      (wb_we_o),
        .wb_adr_o     (wb_adr_o),
        .wb_dat_o     (wb_dat_o),
        .wb_sel_o     (wb_sel_o),
        .wb_ack_i     (wb_ack_i),
        .wb_err_i     (wb_err_i),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .err_count    (err_count),
        .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
    } beat_t;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic          err;
        logic [31:0]   stamp;
    } obs_t;

    beat_t       exp_q[$];
    obs_t        obs_q[$];
    int          n_pass = 0;
    int          n_checks = 0;
    logic [AW-1:0] model_ptr = '0;
    logic [31:0] cyc_cnt = 0;
    logic [31:0] beat_cnt = 0;
    logic [31:0] stb_cycles = 0;

    // Slave model: zero-wait ack while enabled; err on one chosen beat.
    logic        ack_en = 1'b0;
    logic        err_raw = 1'b0;
    logic        err_with_ack = 1'b0;
    logic [31:0] err_beat = 32'hFFFF_FFFF;

    assign wb_err_i = err_raw | (wb_stb_o && (beat_cnt == err_beat));
    assign wb_ack_i = wb_stb_o && ack_en && (err_with_ack || (beat_cnt != err_beat));

    initial forever begin
        @(posedge clk);
        cyc_cnt <= cyc_cnt + 1;
        if (!reset && wb_stb_o && (wb_ack_i || wb_err_i)) beat_cnt <= beat_cnt + 1;
    end

    // Monitor: every terminated beat is popped from the scoreboard and compared.
    initial forever begin
        beat_t e;
        obs_t  o;
        @(negedge clk);
        if (!reset) begin
            if (wb_stb_o) stb_cycles = stb_cycles + 1;
            if (wb_stb_o && (wb_ack_i || wb_err_i)) begin
                o.adr = wb_adr_o;
                o.err = wb_err_i;
                o.stamp = cyc_cnt;
                obs_q.push_back(o);
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_extra: got write adr %h dat %h, want no write",
                             wb_adr_o, wb_dat_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({wb_adr_o, wb_dat_o, wb_sel_o} !== e)
                        $display("FAIL sb_beat: got adr %h dat %h sel %h, want %h %h %h",
                                 wb_adr_o, wb_dat_o, wb_sel_o, e.adr, e.dat, e.sel);
                    else n_pass++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    // Drive a word from posedge+1 until accepted; returns the accepting edge number.
    task automatic push_word(input logic ld, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s, input bit track,
                             output logic [31:0] edge_no);
        logic  rdy;
        int    n;
        beat_t e;
        in_valid = 1'b1;
        in_addr_load = ld;
        in_addr = a;
        in_data = d;
        in_sel = s;
        rdy = 1'b0;
        n = 0;
        while (!rdy && n < 600) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        edge_no = cyc_cnt;
        if (!rdy) begin
            n_checks++;
            $display("FAIL push_stall: in_ready=0 for 600 cycles, want 1");
        end else begin
            e.adr = ld ? a : model_ptr;
            e.dat = d;
            e.sel = s;
            model_ptr = e.adr + AW'(1);
            if (track) exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        ok = (busy === 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_addr_load = 1'b0;
        in_addr = '0;
        in_data = '0;
        in_sel = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b001)
            $display("FAIL reset_ctl: got cyc/stb/we %b, want 001", {wb_cyc_o, wb_stb_o, wb_we_o});
        else n_pass++;
        n_checks++;
        if ({wb_adr_o, wb_dat_o, wb_sel_o} !== '0)
            $display("FAIL reset_bus: got adr %h dat %h sel %h, want 0", wb_adr_o, wb_dat_o,
                     wb_sel_o);
        else n_pass++;
        n_checks++;
        if ({in_ready, busy, fifo_level} !== {1'b1, 1'b0, 5'd0})
            $display("FAIL reset_fifo: got ready %b busy %b level %0d, want 1 0 0",
                     in_ready, busy, fifo_level);
        else n_pass++;
        n_checks++;
        if ({err_count, timeout_count} !== 16'h0000)
            $display("FAIL reset_cnt: got err %0d to %0d, want 0 0", err_count, timeout_count);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] pe, s0;
        int          ob0;
        bit          ok;
        ack_en = 1'b1;
        s0 = stb_cycles;
        ob0 = obs_q.size();
        push_word(1'b1, 27'h100, 32'hDEAD_BEEF, 4'hF, 1'b1, pe);
        wait_idle(ok);
        n_checks++;
        if (!ok) $display("FAIL single_drain: busy %b, want 0", busy);
        else n_pass++;
        n_checks++;
        if (obs_q.size() - ob0 != 1)
            $display("FAIL single_count: got %0d writes, want 1", obs_q.size() - ob0);
        else n_pass++;
        // Accepted on edge pe, level 1 after pe, strobe raised by edge pe+1.
        n_checks++;
        if (obs_q[ob0].stamp !== pe + 1)
            $display("FAIL single_latency: got strobe edge %0d, want %0d", obs_q[ob0].stamp,
                     pe + 1);
        else n_pass++;
        n_checks++;
        if ({stb_cycles - s0, 27'(fifo_level)} !== {32'd1, 27'd0})
            $display("FAIL single_pulse: got stb cycles %0d level %0d, want 1 0",
                     stb_cycles - s0, fifo_level);
        else n_pass++;
    endtask

    task automatic test_burst();
        logic [31:0] pe, s0;
        int          ob0;
        bit          ok;
        s0 = stb_cycles;
        ob0 = obs_q.size();
        push_word(1'b1, 27'h2000, $urandom, 4'hF, 1'b1, pe);
        for (int i = 0; i < 3; i++) push_word(1'b0, 27'h7777, $urandom, 4'(i + 1), 1'b1, s0);
        s0 = stb_cycles - 4 + 4; // snapshot retained below via obs stamps
        wait_idle(ok);
        n_checks++;
        if (!ok || obs_q.size() - ob0 != 4)
            $display("FAIL burst_count: got %0d writes, want 4", obs_q.size() - ob0);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({obs_q[ob0 + i].adr, obs_q[ob0 + i].stamp} !== {27'h2000 + 27'(i), pe + 1 + i})
                $display("FAIL burst_beat%0d: got adr %h edge %0d, want %h %0d", i,
                         obs_q[ob0 + i].adr, obs_q[ob0 + i].stamp, 27'h2000 + 27'(i),
                         pe + 1 + i);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [31:0] pe;
        int          ob0;
        bit          ok;
        ob0 = obs_q.size();
        push_word(1'b1, 27'h7FF_FFFF, 32'h1111_2222, 4'h3, 1'b1, pe);
        push_word(1'b0, 27'h0AB_CDEF, 32'h3333_4444, 4'hC, 1'b1, pe);
        wait_idle(ok);
        n_checks++;
        if (!ok || obs_q.size() - ob0 != 2 || obs_q[ob0 + 1].adr !== 27'h0)
            $display("FAIL wrap_addr: got %0d writes second adr %h, want 2 writes adr 0",
                     obs_q.size() - ob0, obs_q[ob0 + 1].adr);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] pe;
        int          ob0;
        bit          ok;
        logic        leak;
        ack_en = 1'b0;
        ob0 = obs_q.size();
        push_word(1'b1, 27'h3000, $urandom, 4'h1, 1'b1, pe);
        for (int i = 1; i < DEPTH; i++) push_word(1'b0, '0, $urandom, 4'(i), 1'b1, pe);
        @(negedge clk);
        n_checks++;
        if ({in_ready, wb_stb_o, fifo_level} !== {1'b0, 1'b1, 5'd16})
            $display("FAIL bp_full: got ready %b stb %b level %0d, want 0 1 16",
                     in_ready, wb_stb_o, fifo_level);
        else n_pass++;
        @(posedge clk);
        #1;
        // A 17th word must be refused while the slave stalls.
        in_valid = 1'b1;
        in_addr_load = 1'b0;
        in_data = 32'hBAD0_BAD0;
        leak = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (in_ready !== 1'b0) leak = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if ({leak, fifo_level} !== {1'b0, 5'd16})
            $display("FAIL bp_refuse: got ready-seen %b level %0d, want 0 16", leak, fifo_level);
        else n_pass++;
        ack_en = 1'b1;
        wait_idle(ok);
        n_checks++;
        if (!ok || obs_q.size() - ob0 != 16 || exp_q.size() != 0)
            $display("FAIL bp_drain: got %0d writes %0d pending, want 16 0",
                     obs_q.size() - ob0, exp_q.size());
        else n_pass++;
        n_checks++;
        if (obs_q[ob0 + 15].stamp - obs_q[ob0].stamp !== 32'd15)
            $display("FAIL bp_b2b: got span %0d edges, want 15",
                     obs_q[ob0 + 15].stamp - obs_q[ob0].stamp);
        else n_pass++;
    endtask

    task automatic test_error();
        logic [31:0] pe;
        int          ob0;
        bit          ok;
        ack_en = 1'b1;
        err_with_ack = 1'b0;
        err_beat = beat_cnt + 1;
        ob0 = obs_q.size();
        push_word(1'b1, 27'h5000, $urandom, 4'hF, 1'b1, pe);
        push_word(1'b0, '0, $urandom, 4'h5, 1'b1, pe);
        push_word(1'b0, '0, $urandom, 4'hA, 1'b1, pe);
        wait_idle(ok);
        n_checks++;
        if (!ok || obs_q.size() - ob0 != 3 ||
            {obs_q[ob0].err, obs_q[ob0 + 1].err, obs_q[ob0 + 2].err} !== 3'b010)
            $display("FAIL err_beats: got %0d writes err flags %b%b%b, want 3 010",
                     obs_q.size() - ob0, obs_q[ob0].err, obs_q[ob0 + 1].err, obs_q[ob0 + 2].err);
        else n_pass++;
        n_checks++;
        if ({err_count, timeout_count} !== {8'd1, 8'd0})
            $display("FAIL err_count: got err %0d to %0d, want 1 0", err_count, timeout_count);
        else n_pass++;
        // ack and err together count as err.
        err_with_ack = 1'b1;
        err_beat = beat_cnt;
        push_word(1'b1, 27'h5100, $urandom, 4'hF, 1'b1, pe);
        wait_idle(ok);
        err_beat = 32'hFFFF_FFFF;
        err_with_ack = 1'b0;
        n_checks++;
        if (!ok || err_count !== 8'd2)
            $display("FAIL err_both: got err_count %0d, want 2", err_count);
        else n_pass++;
        // err outside a cycle is ignored.
        err_raw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        err_raw = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err_count !== 8'd2)
            $display("FAIL err_idle: got err_count %0d, want 2", err_count);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        logic [31:0] pe, r, f, r2;
        int          ob0, n;
        bit          ok;
        ack_en = 1'b0;
        ob0 = obs_q.size();
        push_word(1'b1, 27'h4000, 32'h0BAD_0BAD, 4'hF, 1'b0, pe);
        r = pe + 1;
        push_word(1'b0, '0, 32'h600D_600D, 4'h6, 1'b1, pe);
        n = 0;
        @(negedge clk);
        while (wb_cyc_o !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        f = cyc_cnt;
        n_checks++;
        if (wb_cyc_o !== 1'b0 || f !== r + TO)
            $display("FAIL to_abort: got cyc %b drop edge %0d, want 0 at %0d", wb_cyc_o, f,
                     r + TO);
        else n_pass++;
        n_checks++;
        if ({timeout_count, 3'b000, fifo_level} !== {8'd1, 8'd1})
            $display("FAIL to_count: got to %0d level %0d, want 1 1", timeout_count, fifo_level);
        else n_pass++;
        ack_en = 1'b1;
        n = 0;
        while (wb_cyc_o !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        r2 = cyc_cnt;
        n_checks++;
        if (wb_cyc_o !== 1'b1 || r2 !== f + 2)
            $display("FAIL to_recover: got restart edge %0d, want %0d", r2, f + 2);
        else n_pass++;
        @(posedge clk);
        #1;
        wait_idle(ok);
        n_checks++;
        if (!ok || obs_q.size() - ob0 != 1 || obs_q[ob0].adr !== 27'h4001)
            $display("FAIL to_next: got %0d writes adr %h, want 1 4001", obs_q.size() - ob0,
                     obs_q[ob0].adr);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] pe;
        int          ob0;
        bit          ok;
        ack_en = 1'b0;
        push_word(1'b1, 27'h6000, $urandom, 4'hF, 1'b1, pe);
        for (int i = 0; i < 5; i++) push_word(1'b0, '0, $urandom, 4'hF, 1'b1, pe);
        @(negedge clk);
        n_checks++;
        if ({wb_stb_o, fifo_level} !== {1'b1, 5'd6})
            $display("FAIL rstmid_pre: got stb %b level %0d, want 1 6", wb_stb_o, fifo_level);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({wb_cyc_o, wb_stb_o, busy, in_ready, fifo_level} !== {4'b0001, 5'd0})
            $display("FAIL rstmid_async: got cyc %b stb %b busy %b ready %b level %0d, want 0001 0",
                     wb_cyc_o, wb_stb_o, busy, in_ready, fifo_level);
        else n_pass++;
        exp_q.delete();
        model_ptr = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ack_en = 1'b1;
        ob0 = obs_q.size();
        push_word(1'b0, 27'h1234, 32'hCAFE_F00D, 4'h9, 1'b1, pe);
        wait_idle(ok);
        n_checks++;
        if (!ok || obs_q.size() - ob0 != 1 || obs_q[ob0].adr !== 27'h0)
            $display("FAIL rstmid_ptr: got %0d writes adr %h, want 1 0", obs_q.size() - ob0,
                     obs_q[ob0].adr);
        else n_pass++;
        n_checks++;
        if ({err_count, timeout_count, exp_q.size() == 0} !== {16'h0000, 1'b1})
            $display("FAIL rstmid_cnt: got err %0d to %0d pending %0d, want 0 0 0",
                     err_count, timeout_count, exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_wrap();
        test_backpressure();
        test_error();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
